// File: rtl/jc_pkg.sv
// Shared constants and helpers for the Johnson counter: default width,
// index-width derivation and the index -> register pattern map.
package jc_pkg;

    localparam int JC_WIDTH_DEF = 5;

    function automatic int jc_iw(input int w);
        return $clog2(2 * w);
    endfunction

    // Index k<=w fills k ones from the LSB; beyond that, zeros fill in from the LSB.
    function automatic logic [15:0] jc_pattern(input int w, input int k);
        int v;
        if (k <= w) v = (1 << k) - 1;
        else        v = ((1 << w) - 1) & ~((1 << (k - w)) - 1);
        return 16'(v);
    endfunction

endpackage

// File: rtl/jc_decode.sv
// Combinational decode of a Johnson register into binary index, one-hot
// state and a legality flag.
module jc_decode
    import jc_pkg::*;
#(
    parameter int WIDTH = JC_WIDTH_DEF,
    localparam int IW   = jc_iw(WIDTH)
) (
    input  logic [WIDTH-1:0]   q_i,
    output logic [IW-1:0]      idx_o,
    output logic [2*WIDTH-1:0] dec_o,
    output logic               legal_o
);

    int pc;
    int edges;

    always_comb begin
        pc    = 0;
        edges = 0;
        for (int i = 0; i < WIDTH; i++) pc += int'(q_i[i]);
        for (int i = 0; i < WIDTH - 1; i++) edges += int'(q_i[i] != q_i[i+1]);
        legal_o = (edges <= 1);
        // Filling phase (LSB set or empty) counts ones; draining phase counts back down.
        if (q_i[0] || q_i == '0) idx_o = IW'(pc);
        else                     idx_o = IW'(2 * WIDTH - pc);
        dec_o = legal_o ? ({{(2*WIDTH-1){1'b0}}, 1'b1} << idx_o) : '0;
    end

endmodule

// File: rtl/johnson_ctr_n.sv
// Up/down Johnson counter with clear, indexed load, wrap pulse and
// illegal-state recovery; all state lives here, decode is combinational.
module johnson_ctr_n
    import jc_pkg::*;
#(
    parameter int WIDTH = JC_WIDTH_DEF,
    localparam int IW   = jc_iw(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               dir,
    input  logic               clr,
    input  logic               load,
    input  logic [IW-1:0]      load_idx,
    output logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] dec,
    output logic [IW-1:0]      idx,
    output logic               wrap,
    output logic               err
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             legal;
    logic             load_ok;
    logic [WIDTH-1:0] load_pat;

    jc_decode #(.WIDTH(WIDTH)) u_dec (
        .q_i     (q_q),
        .idx_o   (idx),
        .dec_o   (dec),
        .legal_o (legal)
    );

    assign load_ok  = int'(load_idx) < 2 * WIDTH;
    assign load_pat = WIDTH'(jc_pattern(WIDTH, int'(load_idx)));

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (!legal) begin
            q_d   = '0;
            err_d = 1'b1;
        end else if (load) begin
            if (load_ok) q_d   = load_pat;
            else         err_d = 1'b1;
        end else if (en) begin
            if (dir) begin
                q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
                wrap_d = (int'(idx) == 2 * WIDTH - 1);
            end else begin
                q_d    = {~q_q[0], q_q[WIDTH-1:1]};
                wrap_d = (idx == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_johnson_ctr_n.sv
// Randomized bench for johnson_ctr_n: an index-level reference model predicts
// q/idx/dec/wrap/err after every edge; directed checks cover reset and recovery.
module tb_johnson_ctr_n;

    localparam int W   = 5;
    localparam int N   = 2 * W;
    localparam int IW  = $clog2(N);
    localparam int W8  = 8;
    localparam int N8  = 2 * W8;
    localparam int IW8 = $clog2(N8);

    logic clk = 1'b0;
    logic rst, en, dir, clr, load;
    logic [IW-1:0]  load_idx;
    logic [W-1:0]   q;
    logic [N-1:0]   dec;
    logic [IW-1:0]  idx;
    logic           wrap, err;

    logic en8, dir8, clr8, load8;
    logic [IW8-1:0] load_idx8;
    logic [W8-1:0]  q8;
    logic [N8-1:0]  dec8;
    logic [IW8-1:0] idx8;
    logic           wrap8, err8;

    johnson_ctr_n #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_idx(load_idx), .q(q), .dec(dec), .idx(idx), .wrap(wrap), .err(err)
    );

    johnson_ctr_n #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .dir(dir8), .clr(clr8), .load(load8),
        .load_idx(load_idx8), .q(q8), .dec(dec8), .idx(idx8), .wrap(wrap8), .err(err8)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int m_idx  = 0;
    bit m_wrap = 0;
    bit m_err  = 0;

    // Expected register for state k: bit i is set while the ones-front has passed it
    // and the zeros-front has not.
    function automatic logic [31:0] pat(input int w, input int k);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = (k <= w) ? (i < k) : (i >= k - w);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    32'(q),    pat(W, m_idx));
        chk({tag, ".idx"},  32'(idx),  32'(m_idx));
        chk({tag, ".dec"},  32'(dec),  32'(1) << m_idx);
        chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        chk({tag, ".err"},  32'(err),  32'(m_err));
    endtask

    task automatic model_edge();
        m_wrap = 0;
        m_err  = 0;
        if (clr) m_idx = 0;
        else if (load) begin
            if (int'(load_idx) < N) m_idx = int'(load_idx);
            else m_err = 1;
        end else if (en) begin
            if (dir) begin m_wrap = (m_idx == N - 1); m_idx = (m_idx + 1) % N; end
            else     begin m_wrap = (m_idx == 0);     m_idx = (m_idx + N - 1) % N; end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    initial begin
        int wraps8;
        int k8;
        rst = 0; en = 0; dir = 1; clr = 0; load = 0; load_idx = '0;
        en8 = 0; dir8 = 1; clr8 = 0; load8 = 0; load_idx8 = '0;
        #12;
        check_all("reset");
        @(negedge clk) rst = 1;

        // Full up cycle, including the 9->0 wrap.
        en = 1; dir = 1;
        for (int i = 0; i < N; i++) tick("up");

        // Down from 0: 9, 8, 7 with a wrap only on the first step.
        dir = 0;
        for (int i = 0; i < 3; i++) tick("down");

        // Illegal-state recovery ignores en.
        en = 0;
        force dut.q_q = 5'b00101;
        #1;
        chk("illegal.dec", 32'(dec), 32'd0);
        release dut.q_q;
        @(posedge clk); #1;
        m_idx = 0; m_wrap = 0; m_err = 1;
        check_all("recover");
        tick("recover_hold");

        // Loads: good index, bad index, clear beats load.
        load = 1; load_idx = IW'(7);  tick("load7");
        load_idx = IW'(12);           tick("load12");
        clr = 1; load_idx = IW'(3);   tick("clr_load");
        clr = 0; load = 0;

        // Random mix with immediate direction changes.
        for (int i = 0; i < 300; i++) begin
            clr      = ($urandom_range(0, 19) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_idx = IW'($urandom_range(0, (1 << IW) - 1));
            en       = ($urandom_range(0, 3) != 0);
            dir      = $urandom_range(0, 1) != 0;
            tick("rand");
        end
        clr = 0; load = 0; en = 0;

        // Async reset between edges from idx 6, then restart from state 0.
        load = 1; load_idx = IW'(6); tick("load6");
        load = 0;
        #2 rst = 0;
        #1;
        m_idx = 0; m_wrap = 0; m_err = 0;
        check_all("async_rst");
        #1 rst = 1;
        en = 1; dir = 1;
        tick("after_rst");
        en = 0;

        // Wide instance: one full up cycle, 16 states and a single wrap.
        wraps8 = 0;
        k8 = 0;
        chk("w8.start", 32'(idx8), 32'd0);
        en8 = 1; dir8 = 1;
        for (int i = 0; i < N8; i++) begin
            @(posedge clk); #1;
            k8 = (k8 + 1) % N8;
            chk("w8.idx", 32'(idx8), 32'(k8));
            chk("w8.q",   32'(q8),   pat(W8, k8));
            if (wrap8) wraps8++;
        end
        chk("w8.wraps", 32'(wraps8), 32'd1);
        en8 = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/johnson_ctr_n.md
JOHNSON_CTR_N -- requirements
Module: johnson_ctr_n

Interface
REQ-001 Parameter WIDTH, default 5, meaning: number of shift stages, giving a 2*WIDTH-state sequence; legal range 2..16.
REQ-002 Parameter IW, default $clog2(2*WIDTH), meaning: index width; it SHALL be derived, not overridden.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  step enable.
REQ-006 dir  input  1  direction: 1 = up, 0 = down.
REQ-007 clr  input  1  synchronous clear to state 0.
REQ-008 load  input  1  synchronous load of the state given by load_idx.
REQ-009 load_idx  input  IW  target state index for load.
REQ-010 q  output  WIDTH  raw Johnson register.
REQ-011 dec  output  2*WIDTH  one-hot decode; bit k set when the state index is k.
REQ-012 idx  output  IW  binary state index, 0..2*WIDTH-1.
REQ-013 wrap  output  1  registered one-cycle pulse on sequence wrap.
REQ-014 err  output  1  registered one-cycle pulse on illegal-state recovery or a bad load.

Function
REQ-015 The up step SHALL be q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; the down step SHALL be q <= {~q[0], q[WIDTH-1:1]}.
REQ-016 Up sequence (WIDTH=5): 00000,00001,00011,00111,01111,11111,11110,11100,11000,10000, then back to 00000; idx 0..9 in that order.
REQ-017 idx SHALL equal popcount(q) when q[0]=1 or q=0, and 2*WIDTH-popcount(q) otherwise; combinational from q, zero latency.
REQ-018 dec SHALL be the one-hot decode of idx, combinational; dec SHALL be all-zero while q is illegal.
REQ-019 Legal q: at most one position i in 0..WIDTH-2 with q[i] != q[i+1]; all other values are illegal.
REQ-020 Per-edge priority SHALL be: clr, then illegal recovery, then load, then en step, then hold.
REQ-021 clr=1: q <= 0; wrap <= 0; err <= 0.
REQ-022 Illegal q at an edge with clr=0: q <= 0 and err <= 1 for one cycle, regardless of en, load or dir.
REQ-023 Load with load_idx < 2*WIDTH: q <= pattern(load_idx); the load SHALL take effect at that edge, and q and idx SHALL show the value after it.
REQ-024 Load with load_idx >= 2*WIDTH: q holds and err <= 1 for one cycle.
REQ-025 wrap <= 1 for one cycle when an up step leaves idx 2*WIDTH-1 or a down step leaves idx 0; wrap SHALL be 0 after loads, clears and holds.
REQ-026 Switching dir between consecutive enabled edges SHALL take effect immediately, with no dead cycle.
REQ-027 en=0 with no clr or load: q holds; wrap and err SHALL be 0.

Reset
REQ-028 rst=0 SHALL immediately force q=0, wrap=0 and err=0, independent of clk; this gives dec=1 (bit 0) and idx=0.
REQ-029 Reset asserted mid-sequence SHALL abort any step; the first rising edge after rst returns high SHALL act on the current inputs from state 0.

Structure
REQ-030 Package jc_pkg SHALL hold the default WIDTH, the IW derivation function, and the function mapping an index to its q pattern.
REQ-031 One combinational sub-module, jc_decode (q -> idx, dec, legal), SHALL be instantiated once; all registers SHALL stay in johnson_ctr_n.

Verification (WIDTH=5 unless stated)
REQ-032 rst=0, then release; en=1, dir=1 for 10 edges -> q follows REQ-016, idx 0..9, dec one-hot each cycle, wrap=1 only in the cycle after the 9->0 step.
REQ-033 From idx 0: dir=0, en=1, 3 edges -> q=10000, 11000, 11100 (idx 9, 8, 7); wrap=1 after the first edge only.
REQ-034 Force q=00101 hierarchically, then release, with en=0 -> next edge q=00000 and err=1 for one cycle, then err=0.
REQ-035 load=1 with load_idx=7 -> q=11100, idx=7; load_idx=12 -> q unchanged, err=1 for one cycle; clr and load together -> q=0.
REQ-036 rst pulsed low between edges at idx 6 -> q=0 at once, with no clk edge; WIDTH=8 full up cycle -> 16 states, one wrap pulse.
